// File: rtl/mac3_acc_if.sv
// mac3_acc bus: pixel/weight lanes, bias and the neuron result.
// p/w: 16 x 8-bit lanes (lane i = [8i+7:8i]); b: signed bias; dout: 22-bit result.
interface mac3_acc_if;
    logic [127:0] p;
    logic [127:0] w;
    logic [7:0]   b;
    logic [21:0]  dout;

    modport master (
        output p,
        output w,
        output b,
        input  dout
    );

    modport slave (
        input  p,
        input  w,
        input  b,
        output dout
    );
endinterface

// File: rtl/mac3_acc.sv
// 16-lane pixel x weight MAC, 4-group accumulate plus bias (one 8x8 digit).
// Ports: clk, rst (sync, active high), bus.slave {p, w, b in; dout out}.
module mac3_acc (
    input  logic      clk,
    input  logic      rst,
    mac3_acc_if.slave bus
);
    localparam int LANES = 16;

    logic signed [16:0] prod_d [LANES];
    logic signed [16:0] prod_q [LANES];
    logic signed [17:0] lvl1   [8];
    logic signed [18:0] lvl2   [4];
    logic signed [19:0] lvl3   [2];
    logic signed [19:0] sum_d;
    logic signed [19:0] sumOUT;
    logic               v1;
    logic               v2;
    logic        [1:0]  g;
    logic signed [21:0] acc;
    logic signed [21:0] acc_in;
    logic signed [21:0] bias_x;
    logic signed [21:0] dout_q;

    // Pixel zero-extended, weight sign-extended to 17 bits; the 17-bit
    // product is exact (-32640..32385).
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_d[i] = $signed({9'd0, bus.p[8*i +: 8]})
                      * $signed({{9{bus.w[8*i+7]}}, bus.w[8*i +: 8]});
        end
    end

    // Adder tree, one bit of growth per level; 20 bits holds the full range.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            lvl1[i] = {prod_q[2*i][16], prod_q[2*i]}
                    + {prod_q[2*i+1][16], prod_q[2*i+1]};
        end
        for (int i = 0; i < 4; i++) begin
            lvl2[i] = {lvl1[2*i][17], lvl1[2*i]}
                    + {lvl1[2*i+1][17], lvl1[2*i+1]};
        end
        for (int i = 0; i < 2; i++) begin
            lvl3[i] = {lvl2[2*i][18], lvl2[2*i]}
                    + {lvl2[2*i+1][18], lvl2[2*i+1]};
        end
        sum_d = lvl3[0] + lvl3[1];
    end

    assign acc_in = acc + {{2{sumOUT[19]}}, sumOUT};
    assign bias_x = {{14{bus.b[7]}}, bus.b};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= '0;
            end
            v1     <= 1'b0;
            v2     <= 1'b0;
            sumOUT <= '0;
            g      <= 2'd0;
            acc    <= '0;
            dout_q <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= prod_d[i];
            end
            v1     <= 1'b1;
            sumOUT <= sum_d;
            v2     <= v1;
            // Fourth sum of a digit closes the result; bias is added here only.
            if (v2) begin
                if (g == 2'd3) begin
                    dout_q <= acc_in + bias_x;
                    acc    <= '0;
                    g      <= 2'd0;
                end else begin
                    acc <= acc_in;
                    g   <= g + 2'd1;
                end
            end
        end
    end

    assign bus.dout = dout_q;
endmodule

// File: tb/tb_mac3_acc.sv
// Bench for mac3_acc: directed extremes plus a random stream with mid-run reset.
// Reference model works on whole groups of 16 lanes with integer arithmetic.
module tb_mac3_acc;
    logic clk;
    logic rst;
    mac3_acc_if bus ();

    mac3_acc dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model state: edges since reset, per-group sums, expected outputs.
    int e = 0;
    int gs [1024];
    int m_sum = 0;
    int m_dout = 0;

    function automatic int group_sum(logic [127:0] p, logic [127:0] w);
        int s;
        int pi;
        int wi;
        s = 0;
        for (int i = 0; i < 16; i++) begin
            pi = p[8*i +: 8];
            wi = $signed(w[8*i +: 8]);
            s += pi * wi;
        end
        return s;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dut_sum();
        int v;
        v = $signed(dut.sumOUT);
        return v;
    endfunction

    function automatic int dut_dout();
        int v;
        v = $signed(bus.dout);
        return v;
    endfunction

    // Group k (k-th edge after reset) yields its sum after edge k+1; a result
    // forms at edges 6, 10, ... from the four groups of edges e-5..e-2.
    always @(posedge clk) begin
        int bi;
        if (rst) begin
            e = 0;
            m_sum = 0;
            m_dout = 0;
        end else if (e < 1000) begin
            e++;
            gs[e] = group_sum(bus.p, bus.w);
            m_sum = (e >= 2) ? gs[e-1] : 0;
            if (e >= 6 && ((e - 6) % 4) == 0) begin
                bi = $signed(bus.b);
                m_dout = gs[e-5] + gs[e-4] + gs[e-3] + gs[e-2] + bi;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("sumOUT_model", dut_sum(), m_sum);
            check("dout_model", dut_dout(), m_dout);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_const(input string name, input logic [7:0] pv,
                             input logic [7:0] wv, input logic [7:0] bv,
                             input int exp_sum, input int exp_dout);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.p = {16{pv}};
        bus.w = {16{wv}};
        bus.b = bv;
        repeat (6) cyc();
        check({name, "_sum"}, dut_sum(), exp_sum);
        check({name, "_dout"}, dut_dout(), exp_dout);
    endtask

    initial begin
        rst = 1'b1;
        bus.p = {16{8'hA5}};
        bus.w = {16{8'h3C}};
        bus.b = 8'h11;
        cyc();
        chk_en = 1'b1;
        cyc();
        cyc();
        check("reset_sum", dut_sum(), 0);
        check("reset_dout", dut_dout(), 0);

        run_const("ones", 8'h01, 8'h01, 8'd11, 16, 75);
        run_const("neg_ext", 8'hFF, 8'h80, 8'h80, -522240, -2089088);
        run_const("pos_ext", 8'hFF, 8'h7F, 8'h7F, 518160, 2072767);

        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.p = {8'd2, 120'd0};
        bus.w = {8'd3, 120'd0};
        bus.b = 8'd0;
        repeat (6) cyc();
        check("lane15_sum", dut_sum(), 6);
        check("lane15_dout", dut_dout(), 24);

        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k == 22) begin
                rst = 1'b1;
                bus.p = {$urandom, $urandom, $urandom, $urandom};
                bus.w = {$urandom, $urandom, $urandom, $urandom};
                cyc();
                check("midrst_dout", dut_dout(), 0);
                check("midrst_sum", dut_sum(), 0);
                rst = 1'b0;
            end
            bus.p = {$urandom, $urandom, $urandom, $urandom};
            bus.w = {$urandom, $urandom, $urandom, $urandom};
            bus.b = 8'($urandom);
            cyc();
        end
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
